vx_tb_boot_sequencer: RTL
=========================

// Module: vx_tb_boot_sequencer
// PURPOSE
//   Testbench boot controller driving the top-level reset domains, memory-loader handshake and DCR
//   programming in a fixed order. Asserts all NUM_RESETS domain resets, then releases them one by one.
//   Then optionally runs the memory loader, replays a DCR write table, and releases the core domain last.
//   Sits between the TB top and the DUT reset/mem/DCR interface signals; replaces hand-written boot code.
// PARAMETERS
//   NUM_RESETS      7    domains; idx 0..NUM_RESETS-2 staged, idx NUM_RESETS-1 = core (released last), >=2
//   HOLD_CYCLES     8    cycles all resets held after start, >=1
//   RELEASE_GAP     4    cycles between successive staged releases, >=1
//   NUM_DCR         4    DCR table depth, >=1
//   LOADER_TIMEOUT  1024 max cycles waiting mem_loader_done; 0 = no timeout
//   DCR_ADDR_W      VX_DCR_ADDR_WIDTH   DCR address width
//   DCR_DATA_W      VX_DCR_DATA_WIDTH   DCR data width
// PORTS
//   clk               in   1                    clock
//   reset_n           in   1                    async active-low reset
//   start             in   1                    boot request, sampled on clk
//   load_mem          in   1                    1 = run loader stage; sampled with start
//   mem_loader_done   in   1                    loader completion, level or pulse
//   dcr_count         in   $clog2(NUM_DCR+1)    DCR writes to issue; sampled with start
//   dcr_addr_tbl      in   NUM_DCR*DCR_ADDR_W   entry i at [i*DCR_ADDR_W +: DCR_ADDR_W]; stable while busy
//   dcr_data_tbl      in   NUM_DCR*DCR_DATA_W   entry i likewise
//   domain_reset      out  NUM_RESETS           active-high reset per domain
//   start_mem_loader  out  1                    one-cycle loader start pulse
//   dcr_write_valid   out  1                    DCR write strobe
//   dcr_write_addr    out  DCR_ADDR_W           DCR address
//   dcr_write_data    out  DCR_DATA_W           DCR data
//   busy              out  1                    sequence in progress
//   done              out  1                    boot complete (RUN)
//   timeout_err       out  1                    sticky loader-timeout flag
// BEHAVIOUR
//   Async reset: state IDLE; domain_reset all 1; start_mem_loader, dcr_write_valid, busy, done,
//     timeout_err = 0; dcr_write_addr/data = 0. Takes effect immediately, including mid-sequence.
//   FSM: IDLE -> ASSERT -> RELEASE -> LOAD -> DCR -> RUN; ERR on timeout.
//   Edge k samples start=1 in IDLE/RUN/ERR: state ASSERT from cycle k+1.
//     All domain_reset=1; done=0; timeout_err=0; busy=1. load_mem and dcr_count latched.
//     dcr_count > NUM_DCR is clamped to NUM_DCR. start while busy is ignored.
//   ASSERT: lasts HOLD_CYCLES cycles, then RELEASE.
//   RELEASE: domain i (i < NUM_RESETS-1) drops at RELEASE-entry + i*RELEASE_GAP. Exit one cycle after
//     the last staged drop. Core domain stays 1.
//   LOAD: if latched load_mem=0, skip to DCR (0 cycles). Else start_mem_loader=1 on first LOAD cycle only.
//     mem_loader_done is honoured only from the cycle after the pulse; a stale high level is ignored.
//     Done seen: go DCR next cycle. Cycle counter reaches LOADER_TIMEOUT (nonzero): go ERR.
//   DCR: one write per cycle, entries 0..dcr_count-1 in order, no gaps. valid/addr/data are registered.
//     dcr_count=0 skips DCR.
//   RUN: entered cycle after last write. Core domain_reset=0, done=1, busy=0.
//   ERR: all domain_reset=1, timeout_err=1, busy=0, done=0. Only start or reset_n exits.
//   Counters are $clog2-sized with no wrap: they saturate or exit before overflow.
// TESTING (defaults; start sampled at edge 0)
//   1 reset_n=0 mid-DCR -> valid=0 and all resets=1 immediately. Release reset_n -> IDLE, no activity.
//   2 start, load_mem=0, dcr_count=0 -> domain_reset[0]=0 @9, [i]=0 @9+4i ([5] @29).
//     Core [6]=0 and done=1 @31.
//   3 load_mem=1, mem_loader_done already high, pulsed 20 cycles after start_mem_loader
//     -> start_mem_loader high exactly 1 cycle; done ignored until the pulse.
//   4 dcr_count=3, tables {A0,A1,A2}/{D0,D1,D2} -> valid 3 consecutive cycles in order;
//     core reset drops the cycle after.
//   5 LOADER_TIMEOUT=16, done never -> timeout_err=1 after 16 cycles, all resets=1.
//     Next start clears it and reboots.
//   6 start during RELEASE ignored; dcr_count=7 with NUM_DCR=4 -> exactly 4 writes.

Source files
------------

// File: rtl/vx_tb_boot_sequencer.sv
// Boot controller for the testbench top: holds every reset domain, releases the
// staged domains one by one, optionally runs the memory loader, replays a DCR
// write table and finally releases the core domain.
module vx_tb_boot_sequencer #(
  parameter int unsigned NUM_RESETS     = 7,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned RELEASE_GAP    = 4,
  parameter int unsigned NUM_DCR        = 4,
  parameter int unsigned LOADER_TIMEOUT = 1024,
  parameter int unsigned DCR_ADDR_W     = 12,
  parameter int unsigned DCR_DATA_W     = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               load_mem,
  input  logic                               mem_loader_done,
  input  logic [$clog2(NUM_DCR+1)-1:0]       dcr_count,
  input  logic [NUM_DCR*DCR_ADDR_W-1:0]      dcr_addr_tbl,
  input  logic [NUM_DCR*DCR_DATA_W-1:0]      dcr_data_tbl,
  output logic [NUM_RESETS-1:0]              domain_reset,
  output logic                               start_mem_loader,
  output logic                               dcr_write_valid,
  output logic [DCR_ADDR_W-1:0]              dcr_write_addr,
  output logic [DCR_DATA_W-1:0]              dcr_write_data,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout_err
);

  // RELEASE spans every staged drop plus one trailing cycle after the last one.
  localparam int unsigned REL_LEN  = (NUM_RESETS - 2) * RELEASE_GAP + 2;
  localparam int unsigned LDR_LAST = (LOADER_TIMEOUT == 0) ? 0 : LOADER_TIMEOUT - 1;
  localparam int unsigned MAX_A    = (HOLD_CYCLES > REL_LEN) ? HOLD_CYCLES : REL_LEN;
  localparam int unsigned MAX_B    = (MAX_A > NUM_DCR) ? MAX_A : NUM_DCR;
  localparam int unsigned MAX_C    = (MAX_B > LOADER_TIMEOUT) ? MAX_B : LOADER_TIMEOUT;
  localparam int unsigned CNT_MAX  = (MAX_C > 1) ? MAX_C : 1;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned DCNT_W   = $clog2(NUM_DCR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_RELEASE,
    S_LOAD,
    S_DCR,
    S_RUN,
    S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load_q, load_d;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
  logic [NUM_RESETS-1:0]   rst_q, rst_d;
  logic                    sml_q, sml_d;
  logic                    valid_q, valid_d;
  logic [DCR_ADDR_W-1:0]   addr_q, addr_d;
  logic [DCR_DATA_W-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Next-state and phase counter; one shared counter is reset on every phase change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_ASSERT;
          cnt_d   = '0;
          load_d  = load_mem;
          dcnt_d  = (32'(dcr_count) > NUM_DCR) ? DCNT_W'(NUM_DCR) : dcr_count;
        end
      end
      S_ASSERT: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_W'(REL_LEN - 1)) begin
          cnt_d = '0;
          if (load_q)              state_d = S_LOAD;
          else if (dcnt_q != '0)   state_d = S_DCR;
          else                     state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        // cnt_q == 0 is the pulse cycle: a done level present then is stale.
        if (cnt_q != '0 && mem_loader_done) begin
          cnt_d   = '0;
          state_d = (dcnt_q != '0) ? S_DCR : S_RUN;
        end else if (LOADER_TIMEOUT != 0 && cnt_q == CNT_W'(LDR_LAST)) begin
          cnt_d   = '0;
          state_d = S_ERR;
        end else if (cnt_q != CNT_W'(CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DCR: begin
        if (32'(cnt_q) + 1 == 32'(dcnt_q)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so every port comes straight from a flop.
  always_comb begin
    rst_d   = '1;
    sml_d   = (state_d == S_LOAD) && (state_q != S_LOAD);
    valid_d = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    busy_d  = state_d inside {S_ASSERT, S_RELEASE, S_LOAD, S_DCR};
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_d)
      S_RELEASE: begin
        for (int unsigned i = 0; i < NUM_RESETS - 1; i++) begin
          rst_d[i] = (32'(cnt_d) < i * RELEASE_GAP);
        end
      end
      S_LOAD: rst_d[NUM_RESETS-2:0] = '0;
      S_DCR: begin
        rst_d[NUM_RESETS-2:0] = '0;
        valid_d = 1'b1;
        for (int unsigned i = 0; i < NUM_DCR; i++) begin
          if (cnt_d == CNT_W'(i)) begin
            addr_d = dcr_addr_tbl[i*DCR_ADDR_W +: DCR_ADDR_W];
            data_d = dcr_data_tbl[i*DCR_DATA_W +: DCR_DATA_W];
          end
        end
      end
      S_RUN: begin
        rst_d  = '0;
        done_d = 1'b1;
      end
      S_ERR: err_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered outputs; reset parks everything in IDLE with resets held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      dcnt_q  <= '0;
      rst_q   <= '1;
      sml_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      dcnt_q  <= dcnt_d;
      rst_q   <= rst_d;
      sml_q   <= sml_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign domain_reset     = rst_q;
  assign start_mem_loader = sml_q;
  assign dcr_write_valid  = valid_q;
  assign dcr_write_addr   = addr_q;
  assign dcr_write_data   = data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout_err      = err_q;

endmodule
